// File: rtl/ram_seq_pkg.sv
// Shared types and constants for the RAM command sequencer.
// RAM_SEQ_VERIFY_EN adds the post-fill read-back state.
package ram_seq_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 4;

    localparam logic [1:0] CMD_WR   = 2'b00;
    localparam logic [1:0] CMD_RD   = 2'b01;
    localparam logic [1:0] CMD_FILL = 2'b10;
    localparam logic [1:0] CMD_DUMP = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_FILL,
        ST_DUMP_RD,
        ST_DUMP_WAIT,
`ifdef RAM_SEQ_VERIFY_EN
        ST_VERIFY,
`endif
        ST_DONE
    } state_e;

endpackage

// File: rtl/ram_seq_ctrl_btn_debounce.sv
// Go-button conditioner: 2-FF synchroniser, stability down-counter and
// rising-edge detector on the debounced level.
module btn_debounce #(
    parameter int DEB_CNT = 1_000_000
)(
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_lvl,
    output logic btn_rise
);
    localparam int CNT_W = (DEB_CNT > 1) ? $clog2(DEB_CNT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEB_CNT - 1);

    logic             sync1;
    logic             sync2;
    logic             lvl_d;
    logic [CNT_W-1:0] cnt;

    // the counter only runs while the synchronised input disagrees with the level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            lvl_d   <= 1'b0;
            btn_lvl <= 1'b0;
            cnt     <= CNT_LOAD;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            lvl_d <= btn_lvl;
            if (sync2 == btn_lvl) begin
                cnt <= CNT_LOAD;
            end else if (cnt == '0) begin
                btn_lvl <= sync2;
                cnt     <= CNT_LOAD;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign btn_rise = btn_lvl & ~lvl_d;

endmodule

// File: rtl/ram_seq_ctrl.sv
// Command sequencer for the 1Kx4 RAM: write, read, fill and paced dump.
// Define RAM_SEQ_VERIFY_EN to add read-back verification after a fill.
//
// state        | meaning
// ST_IDLE      | waiting for a debounced go
// ST_WR        | single write cycle
// ST_RD        | single read, capture to display
// ST_FILL      | one write per cycle, addr+i / data+i
// ST_DUMP_RD   | read word i into the display
// ST_DUMP_WAIT | hold word i on the display
// ST_VERIFY    | re-read the filled range and compare (optional)
// ST_DONE      | one-cycle completion pulse
module ram_seq_ctrl
    import ram_seq_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DEB_CNT    = 1_000_000,
    parameter int STEP_DELAY = 50_000_000
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_go,
    input  logic [1:0]        cmd,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] len_in,
    input  logic [DATA_W-1:0] ram_q,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_wren,
    output logic [DATA_W-1:0] disp_data,
    output logic [ADDR_W-1:0] disp_addr,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int TMR_W = (STEP_DELAY > 2) ? $clog2(STEP_DELAY) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(STEP_DELAY - 2);

    state_e            state;
    state_e            nstate;
    logic              go_lvl;
    logic              go_rise;
    logic              go_acc;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] data_r;
    logic [ADDR_W-1:0] len_r;
    logic [ADDR_W-1:0] idx;
    logic [TMR_W-1:0]  tmr;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_din;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_din;
    logic              last_word;

    btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn_go),
        .btn_lvl  (go_lvl),
        .btn_rise (go_rise)
    );

    assign go_acc    = go_rise & go_lvl & (state == ST_IDLE);
    assign cur_addr  = addr_r + idx;
    assign cur_din   = data_r + idx[DATA_W-1:0];
    assign last_word = (idx == len_r);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate = state;
        case (state)
            ST_IDLE: begin
                if (go_acc) begin
                    case (cmd)
                        CMD_WR:   nstate = ST_WR;
                        CMD_RD:   nstate = ST_RD;
                        CMD_FILL: nstate = ST_FILL;
                        default:  nstate = ST_DUMP_RD;
                    endcase
                end
            end
            ST_WR, ST_RD: nstate = ST_DONE;
            ST_FILL: begin
                if (last_word) begin
`ifdef RAM_SEQ_VERIFY_EN
                    nstate = ST_VERIFY;
`else
                    nstate = ST_DONE;
`endif
                end
            end
            ST_DUMP_RD: nstate = ST_DUMP_WAIT;
            ST_DUMP_WAIT: begin
                if (tmr == '0) begin
                    nstate = last_word ? ST_DONE : ST_DUMP_RD;
                end
            end
`ifdef RAM_SEQ_VERIFY_EN
            ST_VERIFY: begin
                if (last_word) begin
                    nstate = ST_DONE;
                end
            end
`endif
            ST_DONE: nstate = ST_IDLE;
            default: nstate = ST_IDLE;
        endcase
    end

    // outside the driving states the RAM port shows the last value driven
    always_comb begin
        ram_addr = hold_addr;
        ram_din  = hold_din;
        ram_wren = 1'b0;
        busy     = (state != ST_IDLE);
        done     = (state == ST_DONE);
        case (state)
            ST_WR, ST_FILL: begin
                ram_addr = cur_addr;
                ram_din  = cur_din;
                ram_wren = 1'b1;
            end
            ST_RD, ST_DUMP_RD: ram_addr = cur_addr;
`ifdef RAM_SEQ_VERIFY_EN
            ST_VERIFY: ram_addr = cur_addr;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r    <= '0;
            data_r    <= '0;
            len_r     <= '0;
            idx       <= '0;
            tmr       <= '0;
            hold_addr <= '0;
            hold_din  <= '0;
            disp_data <= '0;
            disp_addr <= '0;
        end else begin
            hold_addr <= ram_addr;
            hold_din  <= ram_din;
            if (go_acc) begin
                addr_r <= addr_in;
                data_r <= data_in;
                len_r  <= len_in;
            end
            case (state)
                ST_IDLE: idx <= '0;
                ST_FILL: idx <= last_word ? '0 : idx + 1'b1;
                ST_DUMP_RD: tmr <= TMR_LOAD;
                ST_DUMP_WAIT: begin
                    if (tmr == '0) begin
                        idx <= idx + 1'b1;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
`ifdef RAM_SEQ_VERIFY_EN
                ST_VERIFY: idx <= idx + 1'b1;
`endif
                default: ;
            endcase
            if (state == ST_RD || state == ST_DUMP_RD) begin
                disp_data <= ram_q;
                disp_addr <= cur_addr;
            end
        end
    end

`ifdef RAM_SEQ_VERIFY_EN
    logic err_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (go_acc) begin
            err_r <= 1'b0;
        end else if (state == ST_VERIFY && ram_q != cur_din) begin
            err_r <= 1'b1;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/ram_seq_ctrl.md
Name: ram_seq_ctrl

Overview:
Command sequencer sitting directly upstream of the 1Kx4 single-port RAM. It is driven by the board switch/button adapter, and its ram_addr/ram_din/ram_wren outputs go to the RAM port. It executes single write, single read, block fill and paced block dump, and latches read data for the seven-segment output stage. The raw go-button is debounced internally, so one physical press equals exactly one command.

Parameters:
ADDR_W, 10, RAM address width (1024 words)
DATA_W, 4, RAM word width
DEB_CNT, 1_000_000, cycles btn_go must be stable before it is accepted (10 ms at 100 MHz)
STEP_DELAY, 50_000_000, cycles each word is held on the display during a dump

Ports:
clk  in  1  system clock (100 MHz), all logic on posedge
rst_n  in  1  asynchronous active-low reset
btn_go  in  1  raw go button, active-high, asynchronous to clk
cmd  in  2  00 write, 01 read, 10 fill, 11 dump; sampled on accepted go
addr_in  in  ADDR_W  start address; sampled on go
data_in  in  DATA_W  write data / fill seed; sampled on go
len_in  in  ADDR_W  words minus 1 for fill/dump (0 means 1 word); sampled on go
ram_q  in  DATA_W  RAM read data, valid combinationally for the current ram_addr
ram_addr  out  ADDR_W  RAM address
ram_din  out  DATA_W  RAM write data
ram_wren  out  1  RAM write enable
disp_data  out  DATA_W  last word read, to display
disp_addr  out  ADDR_W  address of disp_data
busy  out  1  high from the cycle after go until done
done  out  1  one-cycle pulse when a command completes
err  out  1  verify mismatch, sticky (see Optional Feature)

Behaviour:
- Reset (asynchronous, immediate): every output is 0 and the FSM goes to IDLE. ram_wren drops combinationally with rst_n, including mid-fill. Debounce state is also cleared.
- Debounce:
  - 2-FF synchroniser, then a counter. The debounced level changes only after DEB_CNT consecutive equal samples.
  - A rising edge of the debounced level gives a one-cycle go pulse.
  - go is ignored while busy=1; it is not queued.
- On a go at cycle N: cmd, addr_in, data_in and len_in are latched, and the FSM leaves IDLE. busy=1 from cycle N+1.
- States: IDLE, WR, RD, FILL, DUMP_RD, DUMP_WAIT, VERIFY (optional), DONE.
- WR (cycle N+1):
  - ram_addr=addr, ram_din=data, ram_wren=1 for exactly one cycle.
  - DONE at N+2: done=1, busy=0 at N+3.
- RD (cycle N+1):
  - ram_addr=addr; disp_data<=ram_q and disp_addr<=addr at the end of the cycle.
  - DONE at N+2.
- FILL:
  - Write i = 0..len runs for len+1 consecutive cycles starting at N+1, with ram_wren held high throughout.
  - ram_addr = (addr+i) mod 2^ADDR_W, so it wraps 1023->0.
  - ram_din = (data+i) mod 2^DATA_W.
  - After the last write, go to DONE (or VERIFY if enabled).
- DUMP, for i = 0..len:
  - DUMP_RD: one cycle, drive ram_addr and capture into disp_data/disp_addr.
  - DUMP_WAIT: STEP_DELAY-1 cycles.
  - After the last word's wait, go to DONE. The final word stays on the display.
- ram_wren is 0 in every state except WR and FILL.
- ram_addr and ram_din hold their last value in IDLE.
- len=1023 with any addr covers all of RAM exactly once.
- Full-width counters for i must not overflow before the compare.
- DONE lasts one cycle (done=1), then returns to IDLE.
- go arriving during DONE is ignored.

Optional Feature:
- Macro: RAM_SEQ_VERIFY_EN.
- Defined:
  - After FILL, the VERIFY state re-reads addr..addr+len, one word per cycle, with the same wrap rule.
  - Each ram_q is compared with (data+i) mod 16.
  - Any mismatch sets err=1. err stays set until the next accepted go or reset.
  - Fill latency grows by len+1 cycles.
- Not defined: there is no VERIFY state, err is tied to 0, and FILL goes straight to DONE.

Decomposition:
- Package ram_seq_pkg holds:
  - cmd encodings CMD_WR, CMD_RD, CMD_FILL, CMD_DUMP
  - the FSM state enum
  - ADDR_W/DATA_W default constants
- Sub-module btn_debounce (params DEB_CNT; ports clk, rst_n, btn_raw, btn_lvl, btn_rise) holds the synchroniser, stability counter and edge detector.
- Everything else stays in ram_seq_ctrl.

Test Plan:
Bench uses DEB_CNT=4, STEP_DELAY=8, and a behavioural 1Kx4 RAM with combinational read.
- Debounce: btn_go toggles 3 times within 3 cycles, then stays high 10 cycles -> exactly one go pulse, one command, done pulses once.
- Write/read: cmd=00, addr=0x005, data=0xA -> ram_wren high exactly one cycle with addr 0x005. Then cmd=01 at the same address -> disp_data=0xA, disp_addr=0x005, done 2 cycles after go.
- Fill wrap: cmd=10, addr=0x3FE, data=0xF, len=3 -> 4 consecutive wren cycles at 0x3FE, 0x3FF, 0x000, 0x001 with data F, 0, 1, 2.
- Dump: cmd=11 over the filled range -> disp_data steps F, 0, 1, 2, each held 8 cycles; done after the last; busy low afterwards.
- Reset mid-fill: assert rst_n=0 during the 2nd write of len=9 -> ram_wren=0 immediately, all outputs 0, FSM in IDLE. The next go is accepted normally.
- Verify (with RAM_SEQ_VERIFY_EN): bench corrupts addr+2 during VERIFY -> err=1 after done. The next accepted go clears err.
